last_value_predictor: RTL and testbench

- Load-value predictor that feeds a predicted word and a recovery request to the hazard controller.
- On a MEM-stage load, it looks up a PC-indexed last-value table with saturating confidence, and supplies a speculative value when confidence is high.
- It then checks the prediction against the D-cache response. On a mismatch it requests a snapshot recovery and holds until the recovery is acknowledged.
- It sits between the MEM stage/D-cache and the hazard controller.

---
 rtl/last_value_predictor_if.sv | 38 +++
 rtl/last_value_predictor.sv | 113 +++++++++++
 tb/tb_last_value_predictor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/last_value_predictor_if.sv
// last_value_predictor_if: MEM/D-cache/hazard-controller side signals of the last-value predictor
// Optional LAST_VALUE_PREDICTOR_STATS_EN adds the prediction/mispredict counters.
interface last_value_predictor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_pc;
    logic                  cache_valid;
    logic [DATA_WIDTH-1:0] cache_data;
    logic                  kill;
    logic                  recover_ack;
    logic                  pred_valid;
    logic [DATA_WIDTH-1:0] pred_data;
    logic                  busy;
    logic                  recover;
    logic [ADDR_WIDTH-1:0] recover_pc;
`ifdef LAST_VALUE_PREDICTOR_STATS_EN
    logic [31:0]           pred_count;
    logic [31:0]           mispred_count;
`endif

    modport master (
        output ld_valid, ld_pc, cache_valid, cache_data, kill, recover_ack,
        input  pred_valid, pred_data, busy, recover, recover_pc
`ifdef LAST_VALUE_PREDICTOR_STATS_EN
        , input pred_count, mispred_count
`endif
    );

    modport slave (
        input  ld_valid, ld_pc, cache_valid, cache_data, kill, recover_ack,
        output pred_valid, pred_data, busy, recover, recover_pc
`ifdef LAST_VALUE_PREDICTOR_STATS_EN
        , output pred_count, mispred_count
`endif
    );
endinterface

// File: rtl/last_value_predictor.sv
// last_value_predictor: PC-indexed last-value load predictor with confidence and snapshot recovery
// Define LAST_VALUE_PREDICTOR_STATS_EN to add pred_count/mispred_count.
module last_value_predictor #(
    parameter int ENTRIES     = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 2
) (
    input logic clk,
    input logic rst_n,
    last_value_predictor_if.slave io
);
    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
    localparam logic [CONF_BITS-1:0] THRESH = CONF_BITS'(CONF_THRESH);

    typedef enum logic [1:0] {IDLE, PRED_WAIT, TRAIN_WAIT, RECOVER} state_t;

    state_t                state;
    logic [ENTRIES-1:0]    t_valid;
    logic [TAG_BITS-1:0]   t_tag [ENTRIES];
    logic [DATA_WIDTH-1:0] t_data [ENTRIES];
    logic [CONF_BITS-1:0]  t_conf [ENTRIES];
    logic [ADDR_WIDTH-1:0] pc_q, cur_pc;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [CONF_BITS-1:0]  conf_inc;
    logic idle, hit, same, confident, accept, pred_start, mis_start, unused_pc;

    // Lookup uses the live PC in IDLE and the latched PC while an access is outstanding.
    always_comb begin
        idle = state == IDLE;
        cur_pc = idle ? io.ld_pc : pc_q;
        idx = cur_pc[INDEX_BITS+1:2];
        tag = cur_pc[ADDR_WIDTH-1:INDEX_BITS+2];
        hit = t_valid[idx] && t_tag[idx] == tag;
        same = hit && t_data[idx] == io.cache_data;
        confident = hit && t_conf[idx] >= THRESH;
        conf_inc = t_conf[idx] == CONF_MAX ? CONF_MAX : t_conf[idx] + 1'b1;
        accept = io.cache_valid && (idle ? io.ld_valid : state != RECOVER && !io.kill);
        pred_start = idle && io.ld_valid && !io.cache_valid && confident;
        mis_start = state == PRED_WAIT && accept && !same;
        unused_pc = ^cur_pc[1:0];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            t_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                t_tag[i] <= '0;
                t_data[i] <= '0;
                t_conf[i] <= '0;
            end
        end else if (accept) begin
            t_valid[idx] <= 1'b1;
            t_tag[idx] <= tag;
            t_data[idx] <= io.cache_data;
            t_conf[idx] <= same ? conf_inc : '0;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            pc_q <= '0;
            io.pred_valid <= 1'b0;
            io.pred_data <= '0;
            io.busy <= 1'b0;
            io.recover <= 1'b0;
            io.recover_pc <= '0;
        end else begin
            case (state)
                IDLE: if (io.ld_valid && !io.cache_valid) begin
                    pc_q <= io.ld_pc;
                    io.busy <= 1'b1;
                    io.pred_valid <= confident;
                    io.pred_data <= t_data[idx];
                    state <= confident ? PRED_WAIT : TRAIN_WAIT;
                end
                TRAIN_WAIT: if (io.kill || io.cache_valid) begin
                    state <= IDLE;
                    io.busy <= 1'b0;
                end
                PRED_WAIT: if (io.kill || io.cache_valid) begin
                    io.pred_valid <= 1'b0;
                    io.busy <= mis_start;
                    io.recover <= mis_start;
                    io.recover_pc <= mis_start ? pc_q : io.recover_pc;
                    state <= mis_start ? RECOVER : IDLE;
                end
                default: if (io.recover_ack) begin
                    state <= IDLE;
                    io.recover <= 1'b0;
                    io.busy <= 1'b0;
                end
            endcase
        end

`ifdef LAST_VALUE_PREDICTOR_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            io.pred_count <= '0;
            io.mispred_count <= '0;
        end else begin
            io.pred_count <= io.pred_count + {31'd0, pred_start};
            io.mispred_count <= io.mispred_count + {31'd0, mis_start};
        end
`else
    logic unused_stats;
    assign unused_stats = pred_start;
`endif
endmodule

// File: tb/tb_last_value_predictor.sv
// tb_last_value_predictor: table-driven load sequences with a prediction scoreboard plus corner cases
module tb_last_value_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    last_value_predictor_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();
    last_value_predictor dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          gap;
        bit          kl;
        bit          pv;
        logic [31:0] pd;
        bit          rec;
    } vec_t;

    typedef struct {
        bit          pv;
        logic [31:0] pd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int checks = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        bus.ld_valid = 1'b1;
        bus.ld_pc = v.pc;
        if (v.gap == 0) begin
            bus.cache_valid = 1'b1;
            bus.cache_data = v.data;
        end
        sb.push_back('{v.pv, v.pd});
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.cache_valid = 1'b0;
        e = sb.pop_front();
        chk("pred_valid", {31'd0, bus.pred_valid}, {31'd0, e.pv});
        if (e.pv) chk("pred_data", bus.pred_data, e.pd);
        chk("busy_after_ld", {31'd0, bus.busy}, (v.gap != 0) ? 32'd1 : 32'd0);
        if (v.gap == 0) return;
        repeat (v.gap - 1) begin
            @(posedge clk); #1;
            chk("pred_hold", {31'd0, bus.pred_valid}, {31'd0, e.pv});
            chk("busy_hold", {31'd0, bus.busy}, 32'd1);
        end
        bus.cache_valid = 1'b1;
        bus.cache_data = v.data;
        bus.kill = v.kl;
        @(posedge clk); #1;
        bus.cache_valid = 1'b0;
        bus.kill = 1'b0;
        chk("pred_drop", {31'd0, bus.pred_valid}, 32'd0);
        chk("recover", {31'd0, bus.recover}, {31'd0, v.rec});
        chk("busy_after_resp", {31'd0, bus.busy}, {31'd0, v.rec});
        if (v.rec) begin
            chk("recover_pc", bus.recover_pc, v.pc);
            repeat (2) @(posedge clk);
            #1;
            chk("recover_hold", {31'd0, bus.recover}, 32'd1);
            bus.recover_ack = 1'b1;
            @(posedge clk); #1;
            bus.recover_ack = 1'b0;
            chk("recover_clear", {31'd0, bus.recover}, 32'd0);
            chk("busy_clear", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        bus.ld_valid = 1'b0;
        bus.ld_pc = '0;
        bus.cache_valid = 1'b0;
        bus.cache_data = '0;
        bus.kill = 1'b0;
        bus.recover_ack = 1'b0;

        vecs.push_back('{32'h100, 32'hAA, 2, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h100, 32'hAA, 1, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h100, 32'hAA, 1, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h100, 32'hAA, 1, 0, 1, 32'hAA, 0});
        vecs.push_back('{32'h100, 32'hAA, 1, 0, 1, 32'hAA, 0});
        vecs.push_back('{32'h100, 32'hBB, 1, 0, 1, 32'hAA, 1});
        vecs.push_back('{32'h100, 32'hBB, 1, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h100, 32'hBB, 1, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h100, 32'hBB, 1, 0, 1, 32'hBB, 0});
        vecs.push_back('{32'h100, 32'hCC, 1, 1, 1, 32'hBB, 0});
        vecs.push_back('{32'h100, 32'hBB, 1, 0, 1, 32'hBB, 0});
        vecs.push_back('{32'h200, 32'h11, 1, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h100, 32'h22, 1, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h104, 32'h55, 0, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h104, 32'h55, 0, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h104, 32'h55, 0, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h104, 32'h55, 1, 0, 1, 32'h55, 0});
        vecs.push_back('{32'h108, 32'h77, 1, 1, 0, 32'h0,  0});
        vecs.push_back('{32'h108, 32'h77, 0, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h108, 32'h77, 0, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h108, 32'h77, 1, 0, 0, 32'h0,  0});
        vecs.push_back('{32'h108, 32'h77, 3, 0, 1, 32'h77, 0});

        #12;
        chk("rst_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        chk("rst_pred_data", bus.pred_data, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_recover", {31'd0, bus.recover}, 32'd0);
        chk("rst_recover_pc", bus.recover_pc, 32'd0);
`ifdef LAST_VALUE_PREDICTOR_STATS_EN
        chk("rst_pred_count", bus.pred_count, 32'd0);
        chk("rst_mispred_count", bus.mispred_count, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

        // recover_ack outside RECOVER must not end an outstanding access
        bus.ld_valid = 1'b1;
        bus.ld_pc = 32'h400;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.recover_ack = 1'b1;
        @(posedge clk); #1;
        bus.recover_ack = 1'b0;
        chk("ack_ignored_busy", {31'd0, bus.busy}, 32'd1);
        bus.cache_valid = 1'b1;
        bus.cache_data = 32'h44;
        @(posedge clk); #1;
        bus.cache_valid = 1'b0;
        chk("ack_ignored_done", {31'd0, bus.busy}, 32'd0);

        // asynchronous reset while in RECOVER
        for (int i = 0; i < 3; i++) run('{32'h10C, 32'h1, 0, 0, 0, 32'h0, 0});
        bus.ld_valid = 1'b1;
        bus.ld_pc = 32'h10C;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        chk("arst_pred_valid", {31'd0, bus.pred_valid}, 32'd1);
        chk("arst_pred_data", bus.pred_data, 32'h1);
        bus.cache_valid = 1'b1;
        bus.cache_data = 32'h2;
        @(posedge clk); #1;
        bus.cache_valid = 1'b0;
        chk("arst_recover_set", {31'd0, bus.recover}, 32'd1);
        chk("arst_recover_pc", bus.recover_pc, 32'h10C);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_recover_clr", {31'd0, bus.recover}, 32'd0);
        chk("arst_busy_clr", {31'd0, bus.busy}, 32'd0);
        chk("arst_pred_clr", {31'd0, bus.pred_valid}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run('{32'h10C, 32'h2, 1, 0, 0, 32'h0, 0});
        run('{32'h100, 32'h22, 2, 0, 0, 32'h0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
